// File: rtl/chaining_scoreboard.sv
// Chaining scoreboard: tracks up to ENTRIES in-flight vector writers and
// answers, per read port, whether a reader may consume a vreg without a RAW
// hazard against an older writer that has not yet finished that register.
module chaining_scoreboard #(
  parameter int ENTRIES = 4,
  parameter int NREAD   = 2,
  parameter int REGW    = 5,
  parameter int IDXW    = 3,
  parameter int MASKW   = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enq_valid,
  output logic                          enq_ready,
  input  logic                          enq_vd_valid,
  input  logic [REGW-1:0]               enq_vd,
  input  logic [IDXW-1:0]               enq_instIndex,
  input  logic [MASKW-1:0]              enq_elementMask,
  input  logic                          update_valid,
  input  logic [IDXW-1:0]               update_instIndex,
  input  logic [$clog2(MASKW)-1:0]      update_offset,
  input  logic                          release_valid,
  input  logic [IDXW-1:0]               release_instIndex,
  input  logic [NREAD*REGW-1:0]         read_vs,
  input  logic [NREAD*IDXW-1:0]         read_instructionIndex,
  output logic [NREAD-1:0]              checkResult,
  output logic [$clog2(ENTRIES):0]      occupancy,
  output logic                          full
);

  localparam int OFFW = $clog2(MASKW);
  localparam int OCCW = $clog2(ENTRIES) + 1;

  typedef struct packed {
    logic             valid;
    logic             vd_valid;
    logic [REGW-1:0]  vd;
    logic [IDXW-1:0]  idx;
    logic [MASKW-1:0] mask;
  } slot_t;

  slot_t slots [ENTRIES];

  logic [ENTRIES-1:0] valid_vec;
  logic [ENTRIES-1:0] alloc_oh;
  logic [ENTRIES-1:0] rel_hit;
  logic [ENTRIES-1:0] upd_hit;
  logic [OCCW-1:0]    rel_count;
  logic [MASKW-1:0]   enq_mask_merged;
  logic               alloc;
  logic               found;

  // True when this slot holds a write the reader must wait for.
  function automatic logic slot_conflict(input slot_t s,
                                         input logic [REGW-1:0] rd_vs,
                                         input logic [IDXW-1:0] rd_idx);
    logic            same;
    logic            older;
    logic            in_win;
    logic            hit;
    logic [REGW-1:0] off;
    same   = (rd_idx == s.idx);
    // Age compare on the low bits, flipped when the wrap bits differ.
    older  = same | ((rd_idx[IDXW-2:0] < s.idx[IDXW-2:0]) ^ rd_idx[IDXW-1] ^ s.idx[IDXW-1]);
    // Modular subtraction lets the register group wrap past the last vreg.
    off    = rd_vs - s.vd;
    in_win = ({1'b0, off} < (REGW+1)'(MASKW));
    hit    = s.vd_valid & in_win & ~s.mask[off[OFFW-1:0]];
    return s.valid & hit & ~older & ~same;
  endfunction

  // Per-slot match vectors for release/update and the release count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    valid_vec = '0;
    rel_hit   = '0;
    upd_hit   = '0;
    rel_count = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      valid_vec[e] = slots[e].valid;
      rel_hit[e]   = release_valid & slots[e].valid & (slots[e].idx == release_instIndex);
      upd_hit[e]   = update_valid  & slots[e].valid & (slots[e].idx == update_instIndex);
      if (rel_hit[e]) rel_count = rel_count + OCCW'(1);
    end
  end

  // Lowest-numbered free slot, one-hot, gated by an accepted allocate.
  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (!valid_vec[e] && !found) begin
        alloc_oh[e] = alloc;
        found       = 1'b1;
      end
    end
  end

  // Capacity is judged on registered state only; releases free a slot next cycle.
  assign enq_ready = ~&valid_vec;
  assign alloc     = enq_valid & enq_ready;
  assign full      = (occupancy == OCCW'(ENTRIES));

  // A writeback for the writer being allocated right now folds into its initial mask.
  assign enq_mask_merged = enq_elementMask |
    ((update_valid && (update_instIndex == enq_instIndex)) ? (MASKW'(1) << update_offset) : '0);

  // Slot storage: allocate, then release (wins over update), then mask update.
  always_ff @(posedge clock) begin
    for (int e = 0; e < ENTRIES; e++) begin
      // NOTE: only the valid bits are reset; record payload is don't-care while invalid,
      // so the data fields stay reset-free.
      if (reset) begin
        slots[e].valid <= 1'b0;
      end else if (alloc_oh[e]) begin
        // NOTE: state is always written with non-blocking assignments so every slot
        // sees the pre-edge values of the shared match vectors.
        slots[e] <= {1'b1, enq_vd_valid, enq_vd, enq_instIndex, enq_mask_merged};
      end else if (rel_hit[e]) begin
        slots[e].valid <= 1'b0;
      end else if (upd_hit[e]) begin
        slots[e].mask[update_offset] <= 1'b1;
      end
    end
  end

  // Occupancy counter: plus one for an accepted allocate, minus every released slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCCW'(alloc) - rel_count;
    end
  end

  // Read-port hazard check against registered slot state only.
  always_comb begin
    checkResult = '1;
    for (int p = 0; p < NREAD; p++) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (slot_conflict(slots[e], read_vs[p*REGW +: REGW],
                          read_instructionIndex[p*IDXW +: IDXW])) begin
          checkResult[p] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chaining_scoreboard.sv
// Directed bench for chaining_scoreboard: linear stimulus with hand-computed
// expected checkResult / occupancy / full / enq_ready values.
module tb_chaining_scoreboard;

  logic        clock;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic        enq_vd_valid;
  logic [4:0]  enq_vd;
  logic [2:0]  enq_instIndex;
  logic [7:0]  enq_elementMask;
  logic        update_valid;
  logic [2:0]  update_instIndex;
  logic [2:0]  update_offset;
  logic        release_valid;
  logic [2:0]  release_instIndex;
  logic [9:0]  read_vs;
  logic [5:0]  read_instructionIndex;
  logic [1:0]  checkResult;
  logic [2:0]  occupancy;
  logic        full;

  int checks = 0;
  int errors = 0;

  chaining_scoreboard dut (
    .clock                 (clock),
    .reset                 (reset),
    .enq_valid             (enq_valid),
    .enq_ready             (enq_ready),
    .enq_vd_valid          (enq_vd_valid),
    .enq_vd                (enq_vd),
    .enq_instIndex         (enq_instIndex),
    .enq_elementMask       (enq_elementMask),
    .update_valid          (update_valid),
    .update_instIndex      (update_instIndex),
    .update_offset         (update_offset),
    .release_valid         (release_valid),
    .release_instIndex     (release_instIndex),
    .read_vs               (read_vs),
    .read_instructionIndex (read_instructionIndex),
    .checkResult           (checkResult),
    .occupancy             (occupancy),
    .full                  (full)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // One clock edge, then drop the single-cycle strobes.
  task automatic tick();
    @(posedge clock);
    #1;
    enq_valid     = 1'b0;
    update_valid  = 1'b0;
    release_valid = 1'b0;
  endtask

  task automatic enq(input logic [4:0] vd, input logic [2:0] idx, input logic [7:0] mask);
    enq_valid       = 1'b1;
    enq_vd_valid    = 1'b1;
    enq_vd          = vd;
    enq_instIndex   = idx;
    enq_elementMask = mask;
  endtask

  task automatic upd(input logic [2:0] idx, input logic [2:0] off);
    update_valid     = 1'b1;
    update_instIndex = idx;
    update_offset    = off;
  endtask

  task automatic rel(input logic [2:0] idx);
    release_valid     = 1'b1;
    release_instIndex = idx;
  endtask

  task automatic set_rd(input int p, input logic [4:0] vs, input logic [2:0] idx);
    read_vs[p*5 +: 5]               = vs;
    read_instructionIndex[p*3 +: 3] = idx;
  endtask

  task automatic check_cr(input string tag, input logic [1:0] expected);
    #1;
    check(tag, 32'(checkResult), 32'(expected));
  endtask

  initial begin
    reset = 1'b1;
    enq_valid = 1'b0; enq_vd_valid = 1'b0; enq_vd = '0; enq_instIndex = '0; enq_elementMask = '0;
    update_valid = 1'b0; update_instIndex = '0; update_offset = '0;
    release_valid = 1'b0; release_instIndex = '0;
    read_vs = '0; read_instructionIndex = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    set_rd(0, 5'd3, 3'd1); set_rd(1, 5'd3, 3'd1);
    check_cr("reset_cr", 2'b11);
    check("reset_occ", 32'(occupancy), 32'd0);
    check("reset_ready", 32'(enq_ready), 32'd1);
    check("reset_full", 32'(full), 32'd0);

    // Writer vd=8 idx=1; reader idx=2 on v10 conflicts, same inst on port 1 is safe.
    enq(5'd8, 3'd1, 8'h00);
    tick();
    set_rd(0, 5'd10, 3'd2); set_rd(1, 5'd3, 3'd1);
    check_cr("raw_in_window", 2'b10);
    check("occ_one", 32'(occupancy), 32'd1);
    upd(3'd1, 3'd2);
    tick();
    check_cr("update_clears", 2'b11);
    // v16 is offset 8 (outside), v15 is offset 7 (still pending).
    set_rd(0, 5'd16, 3'd2); set_rd(1, 5'd15, 3'd2);
    check_cr("window_edge", 2'b01);

    // Writer vd=30 idx=5: window wraps to v0..v5.
    enq(5'd30, 3'd5, 8'h00);
    tick();
    set_rd(0, 5'd1, 3'd6); set_rd(1, 5'd1, 3'd4);
    check_cr("wrap_younger_older", 2'b10);
    check("occ_two", 32'(occupancy), 32'd2);
    set_rd(0, 5'd1, 3'd5); set_rd(1, 5'd11, 3'd4);
    check_cr("same_inst_and_age", 2'b01);

    // Age wrap: record idx7 vd12, record idx0 vd20.
    enq(5'd12, 3'd7, 8'h00);
    tick();
    enq(5'd20, 3'd0, 8'h00);
    tick();
    check("full_occ", 32'(occupancy), 32'd4);
    check("full_flag", 32'(full), 32'd1);
    check("full_ready", 32'(enq_ready), 32'd0);
    set_rd(0, 5'd16, 3'd0); set_rd(1, 5'd20, 3'd7);
    check_cr("age_wrap_a", 2'b10);
    set_rd(0, 5'd20, 3'd1); set_rd(1, 5'd16, 3'd6);
    check_cr("age_wrap_b", 2'b10);

    // Release idx7 while full with enq pending: enq is dropped.
    rel(3'd7);
    enq(5'd4, 3'd2, 8'h00);
    tick();
    check("drop_occ", 32'(occupancy), 32'd3);
    check("drop_full", 32'(full), 32'd0);
    check("drop_ready", 32'(enq_ready), 32'd1);
    set_rd(0, 5'd4, 3'd3); set_rd(1, 5'd16, 3'd0);
    check_cr("drop_no_record", 2'b11);
    enq(5'd4, 3'd2, 8'h00);
    tick();
    check("refill_occ", 32'(occupancy), 32'd4);
    check("refill_full", 32'(full), 32'd1);
    check_cr("refill_record", 2'b10);

    // Free idx1, then allocate idx3 with a same-cycle update of offset 0.
    rel(3'd1);
    tick();
    check("rel_occ", 32'(occupancy), 32'd3);
    enq(5'd24, 3'd3, 8'h00);
    upd(3'd3, 3'd0);
    tick();
    check("alloc_upd_occ", 32'(occupancy), 32'd4);
    set_rd(0, 5'd24, 3'd4); set_rd(1, 5'd25, 3'd4);
    check_cr("alloc_upd_mask", 2'b01);

    // Release idx3 with same-cycle update: release wins.
    rel(3'd3);
    upd(3'd3, 3'd1);
    tick();
    check("rel_upd_occ", 32'(occupancy), 32'd3);
    check_cr("rel_upd_freed", 2'b11);

    // Same-cycle enq and release of idx2: old freed, new allocated.
    rel(3'd2);
    enq(5'd4, 3'd2, 8'h00);
    tick();
    check("enq_rel_occ", 32'(occupancy), 32'd3);
    set_rd(0, 5'd4, 3'd3); set_rd(1, 5'd5, 3'd1);
    check_cr("enq_rel_record", 2'b10);

    // Update with no matching writer is ignored.
    upd(3'd6, 3'd0);
    tick();
    check("nomatch_occ", 32'(occupancy), 32'd3);
    check_cr("nomatch_cr", 2'b10);

    // Reset mid-operation with an enq pending.
    reset = 1'b1;
    enq(5'd9, 3'd4, 8'h00);
    tick();
    reset = 1'b0;
    check("midrst_occ", 32'(occupancy), 32'd0);
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_ready", 32'(enq_ready), 32'd1);
    set_rd(0, 5'd4, 3'd3); set_rd(1, 5'd9, 3'd5);
    check_cr("midrst_cr", 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
